sig_thresh_det: RTL and testbench

SIG_THRESH_DET -- requirements
Module: sig_thresh_det

---
 rtl/sig_thresh_det_pkg.sv | 16 +
 rtl/sig_thresh_det_if.sv | 28 ++
 rtl/sig_thresh_det_win_minmax.sv | 58 +++++
 rtl/sig_thresh_det.sv | 99 +++++++++
 tb/tb_sig_thresh_det.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sig_thresh_det_pkg.sv
// Shared constants and types for the signal threshold detector and its bench.
package sig_thresh_det_pkg;

  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } cmp_state_e;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (v == {PERIOD_W{1'b1}}) ? v : v + PERIOD_W'(1);
  endfunction

endpackage

// File: rtl/sig_thresh_det_if.sv
// Sample input and sliced/measured outputs of the threshold detector.
// en is a one-way qualifier: in_dat is consumed on every rising clk edge where
// en=1; there is no ready, the detector always accepts. All outputs are registered.
interface sig_thresh_det_if;
  import sig_thresh_det_pkg::*;

  logic [7:0]          in_dat;
  logic                en;
  logic                dig_out;
  logic                rise_pls;
  logic                fall_pls;
  logic [7:0]          vpp;
  logic [7:0]          thr;
  logic                win_vld;
  logic [PERIOD_W-1:0] period;
  logic                period_vld;
  cmp_state_e          state;

  modport master (
    output in_dat, en,
    input  dig_out, rise_pls, fall_pls, vpp, thr, win_vld, period, period_vld, state
  );

  modport slave (
    input  in_dat, en,
    output dig_out, rise_pls, fall_pls, vpp, thr, win_vld, period, period_vld, state
  );
endinterface

// File: rtl/sig_thresh_det_win_minmax.sv
// Windowed min/max tracker: every WIN enabled samples publishes peak-to-peak
// amplitude and the mid-point slicing threshold.
module win_minmax
  import sig_thresh_det_pkg::*;
#(
  parameter int WIN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_dat,
  input  logic       en,
  output logic [7:0] vpp,
  output logic [7:0] thr,
  output logic       win_vld
);

  localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  logic [CNT_W-1:0] cnt;
  logic [7:0]       run_min, run_max;
  logic [7:0]       nxt_min, nxt_max, span;

  // Running extremes including the current sample; the first sample of a window reloads both.
  always_comb begin
    nxt_min = in_dat;
    nxt_max = in_dat;
    if (cnt != '0) begin
      nxt_min = (in_dat < run_min) ? in_dat : run_min;
      nxt_max = (in_dat > run_max) ? in_dat : run_max;
    end
    span = nxt_max - nxt_min;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      run_min <= '0;
      run_max <= '0;
      vpp     <= '0;
      thr     <= '0;
      win_vld <= 1'b0;
    end else begin
      win_vld <= 1'b0;
      if (en) begin
        cnt     <= cnt + CNT_W'(1);
        run_min <= nxt_min;
        run_max <= nxt_max;
        if (cnt == LAST) begin
          vpp     <= span;
          thr     <= nxt_min + (span >> 1);
          win_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sig_thresh_det.sv
// Hysteresis slicer with adaptive threshold and rising-edge period measurement.
module sig_thresh_det
  import sig_thresh_det_pkg::*;
#(
  parameter int WIN  = 256,
  parameter int HYST = 4
) (
  input  logic             clk,
  input  logic             rst,
  sig_thresh_det_if.slave  bus
);

  logic [7:0]          vpp, thr;
  logic                win_vld;
  cmp_state_e          state;
  logic                dig_out, rise_pls, fall_pls, period_vld;
  logic                win_seen, rise_seen;
  logic [PERIOD_W-1:0] gap, period;
  logic [8:0]          in_ext;
  logic                above, below;

  win_minmax #(.WIN(WIN)) u_win (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (bus.in_dat),
    .en      (bus.en),
    .vpp     (vpp),
    .thr     (thr),
    .win_vld (win_vld)
  );

  // 9-bit compares make the saturated cases (thr+HYST>=255, thr-HYST<=0) unreachable naturally.
  assign in_ext = {1'b0, bus.in_dat};
  assign above  = in_ext > ({1'b0, thr} + 9'(HYST));
  assign below  = (in_ext + 9'(HYST)) < {1'b0, thr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_INIT;
      dig_out    <= 1'b0;
      rise_pls   <= 1'b0;
      fall_pls   <= 1'b0;
      win_seen   <= 1'b0;
      rise_seen  <= 1'b0;
      gap        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      rise_pls   <= 1'b0;
      fall_pls   <= 1'b0;
      period_vld <= 1'b0;
      gap        <= sat_inc(gap);
      if (win_vld) win_seen <= 1'b1;
      if (bus.en) begin
        case (state)
          ST_INIT: begin
            if (win_seen || win_vld) begin
              state   <= (bus.in_dat >= thr) ? ST_HIGH : ST_LOW;
              dig_out <= (bus.in_dat >= thr);
            end
          end
          ST_LOW: begin
            if (above) begin
              state     <= ST_HIGH;
              dig_out   <= 1'b1;
              rise_pls  <= 1'b1;
              rise_seen <= 1'b1;
              gap       <= '0;
              // gap holds edges since the last rise minus one, so the distance is gap+1.
              if (rise_seen) begin
                period     <= sat_inc(gap);
                period_vld <= 1'b1;
              end
            end
          end
          ST_HIGH: begin
            if (below) begin
              state    <= ST_LOW;
              dig_out  <= 1'b0;
              fall_pls <= 1'b1;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  assign bus.vpp        = vpp;
  assign bus.thr        = thr;
  assign bus.win_vld    = win_vld;
  assign bus.dig_out    = dig_out;
  assign bus.rise_pls   = rise_pls;
  assign bus.fall_pls   = fall_pls;
  assign bus.period     = period;
  assign bus.period_vld = period_vld;
  assign bus.state      = state;

endmodule

// File: tb/tb_sig_thresh_det.sv
// Directed and randomized bench for sig_thresh_det (WIN=4, HYST=2) with a
// sample-list reference model.
module tb_sig_thresh_det;
  import sig_thresh_det_pkg::*;

  localparam int WIN  = 4;
  localparam int HYST = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sig_thresh_det_if bus();

  sig_thresh_det #(.WIN(WIN), .HYST(HYST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  m_vpp, m_thr;
  logic        m_wv, m_rise, m_fall, m_pv;
  logic [15:0] m_period;
  bit          m_decided, m_high, m_seen, m_have_prev;
  longint      m_cyc, m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_vpp = 0; m_thr = 0; m_wv = 0; m_rise = 0; m_fall = 0; m_pv = 0; m_period = 0;
    m_decided = 0; m_high = 0; m_seen = 0; m_have_prev = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic e);
    logic       nr, nf, nwv;
    logic [7:0] nvpp, nthr;
    int         mn, mx;
    nr = 0; nf = 0; nwv = 0; nvpp = m_vpp; nthr = m_thr;
    m_cyc++;
    if (e) begin
      if (!m_decided) begin
        if (m_seen || m_wv) begin
          m_decided = 1;
          m_high = (d >= m_thr);
        end
      end else if (!m_high && int'(d) > int'(m_thr) + HYST) begin
        m_high = 1; nr = 1;
      end else if (m_high && int'(d) < int'(m_thr) - HYST) begin
        m_high = 0; nf = 1;
      end
      exp_q.push_back(d);
      if (exp_q.size() == WIN) begin
        mn = 255; mx = 0;
        foreach (exp_q[i]) begin
          if (int'(exp_q[i]) < mn) mn = int'(exp_q[i]);
          if (int'(exp_q[i]) > mx) mx = int'(exp_q[i]);
        end
        nvpp = 8'(mx - mn);
        nthr = 8'(mn + (mx - mn) / 2);
        nwv = 1;
        exp_q.delete();
      end
    end
    if (m_wv) m_seen = 1;
    m_pv = 0;
    if (nr) begin
      if (m_have_prev) begin
        m_period = (m_cyc - m_prev > 65535) ? 16'hFFFF : 16'(m_cyc - m_prev);
        m_pv = 1;
      end
      m_prev = m_cyc;
      m_have_prev = 1;
    end
    m_rise = nr; m_fall = nf; m_wv = nwv; m_vpp = nvpp; m_thr = nthr;
  endtask

  task automatic check_all();
    cmp_state_e es;
    es = !m_decided ? ST_INIT : (m_high ? ST_HIGH : ST_LOW);
    chk("dig_out",    32'(bus.dig_out),    32'(m_decided && m_high));
    chk("rise_pls",   32'(bus.rise_pls),   32'(m_rise));
    chk("fall_pls",   32'(bus.fall_pls),   32'(m_fall));
    chk("vpp",        32'(bus.vpp),        32'(m_vpp));
    chk("thr",        32'(bus.thr),        32'(m_thr));
    chk("win_vld",    32'(bus.win_vld),    32'(m_wv));
    chk("period",     32'(bus.period),     32'(m_period));
    chk("period_vld", 32'(bus.period_vld), 32'(m_pv));
    chk("state",      32'(bus.state),      32'(es));
  endtask

  task automatic step(input logic [7:0] d, input logic e);
    bus.in_dat = d;
    bus.en     = e;
    model_step(d, e);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.in_dat = 8'hFF;
    bus.en = 1'b1;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
  endtask

  initial begin
    m_cyc = 0;
    do_reset(3);

    // First window 10,50,30,20
    step(8'd10, 1); step(8'd50, 1); step(8'd30, 1); step(8'd20, 1);
    chk("win1_vld", 32'(bus.win_vld), 32'd1);
    chk("win1_vpp", 32'(bus.vpp), 32'd40);
    chk("win1_thr", 32'(bus.thr), 32'd30);

    // Leave INIT without a pulse, then hysteresis around thr=30
    step(8'd28, 1);
    chk("init_exit_state", 32'(bus.state), 32'(ST_LOW));
    chk("init_exit_nopls", 32'(bus.rise_pls | bus.fall_pls), 32'd0);
    step(8'd32, 1);
    chk("hyst_32_norise", 32'(bus.rise_pls), 32'd0);
    step(8'd33, 1);
    chk("hyst_33_rise", 32'(bus.rise_pls), 32'd1);
    step(8'd28, 1);
    chk("hyst_28_nofall", 32'(bus.fall_pls), 32'd0);
    chk("win2_thr", 32'(bus.thr), 32'd30);
    step(8'd27, 1);
    chk("hyst_27_fall", 32'(bus.fall_pls), 32'd1);

    // Rising crossings 100 then 70000 cycles apart
    step(8'd40, 1);
    step(8'd20, 1);
    idle(98);
    step(8'd40, 1);
    chk("period_100", 32'(bus.period), 32'd100);
    chk("period_100_vld", 32'(bus.period_vld), 32'd1);
    step(8'd20, 1);
    idle(69998);
    step(8'd40, 1);
    chk("period_sat", 32'(bus.period), 32'd65535);
    chk("period_sat_vld", 32'(bus.period_vld), 32'd1);

    // Constant 255 window: LOW can never rise
    do_reset(1);
    repeat (4) step(8'd255, 1);
    chk("c255_vpp", 32'(bus.vpp), 32'd0);
    chk("c255_thr", 32'(bus.thr), 32'd255);
    step(8'd254, 1);
    repeat (7) step(8'd255, 1);
    chk("c255_low", 32'(bus.dig_out), 32'd0);

    // Constant 1 window: HIGH can never fall
    do_reset(1);
    repeat (4) step(8'd1, 1);
    chk("c1_thr", 32'(bus.thr), 32'd1);
    repeat (7) step(8'd1, 1);
    chk("c1_high", 32'(bus.dig_out), 32'd1);

    // Reset mid-window discards partial min/max; en gaps are transparent
    do_reset(1);
    step(8'd200, 1); step(8'd0, 1);
    do_reset(1);
    step(8'd5, 1); idle(1); step(8'd9, 1); idle(2); step(8'd7, 1);
    chk("rst_mid_nowin", 32'(bus.win_vld), 32'd0);
    step(8'd6, 1);
    chk("rst_mid_vpp", 32'(bus.vpp), 32'd4);
    chk("rst_mid_thr", 32'(bus.thr), 32'd7);
    chk("rst_mid_vld", 32'(bus.win_vld), 32'd1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      step(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
